// File: rtl/pulse_interval_demod.sv
// rtl/pulse_interval_demod.sv - pulse-gap interval demodulator with one-entry output buffer
// Optional macro PID_INSIG_SYNC_EN adds a 2-flop input synchronizer (reset to 1).
module pulse_interval_demod #(
    parameter int CNT_W   = 16,
    parameter int DATA_W  = 8,
    parameter int PERIOD0 = 24900,
    parameter int PERIOD1 = 21300,
    parameter int TOL     = 1000,
    parameter int MIN_LOW = 16,
    parameter int TIMEOUT = 49800
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              insig,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sym_err,
    output logic              overflow,
    output logic [7:0]        err_count
);

    localparam int RUN_W = $clog2(MIN_LOW + 1);
    localparam int BC_W  = $clog2(DATA_W + 1);

    localparam logic [31:0] LO0 = 32'((PERIOD0 > TOL) ? PERIOD0 - TOL : 0);
    localparam logic [31:0] HI0 = 32'(PERIOD0 + TOL);
    localparam logic [31:0] LO1 = 32'((PERIOD1 > TOL) ? PERIOD1 - TOL : 0);
    localparam logic [31:0] HI1 = 32'(PERIOD1 + TOL);

    typedef enum logic [1:0] {ARMED, IDLE, MEASURE} state_t;

    state_t            state, state_n;
    logic              sig;
    logic [RUN_W-1:0]  low_run;
    logic              qual;
    logic [CNT_W-1:0]  cnt;
    logic [BC_W-1:0]   bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] word_next;
    logic [31:0]       cnt_ext;
    logic              win0, win1, sym_valid;
    logic              start, classify, timeout, complete, bad_sym;

`ifdef PID_INSIG_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clock) begin
        if (reset) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], insig};
    end

    assign sig = sync_q[1];
`else
    assign sig = insig;
`endif

    // Run length saturates at MIN_LOW so a long gap yields exactly one qualified edge.
    always_ff @(posedge clock) begin
        if (reset)                         low_run <= '0;
        else if (sig)                      low_run <= '0;
        else if (low_run != RUN_W'(MIN_LOW)) low_run <= low_run + RUN_W'(1);
    end

    assign qual = !sig && (low_run == RUN_W'(MIN_LOW - 1));

    assign cnt_ext   = 32'(cnt);
    assign win0      = (cnt_ext >= LO0) && (cnt_ext <= HI0);
    assign win1      = (cnt_ext >= LO1) && (cnt_ext <= HI1);
    assign sym_valid = win0 || win1;
    assign word_next = {win1, shreg[DATA_W-1:1]};
    assign complete  = classify && sym_valid && (bit_cnt == BC_W'(DATA_W - 1));
    assign bad_sym   = timeout || (classify && !sym_valid);

    always_ff @(posedge clock) begin
        if (reset) state <= ARMED;
        else       state <= state_n;
    end

    always_comb begin
        state_n  = state;
        start    = 1'b0;
        classify = 1'b0;
        timeout  = 1'b0;
        case (state)
            ARMED: state_n = IDLE;
            IDLE: begin
                if (qual) begin
                    start   = 1'b1;
                    state_n = MEASURE;
                end
            end
            MEASURE: begin
                if (cnt == CNT_W'(TIMEOUT)) begin
                    timeout = 1'b1;
                    state_n = IDLE;
                end else if (qual) begin
                    classify = 1'b1;
                end
            end
            default: state_n = ARMED;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            sym_err   <= 1'b0;
            overflow  <= 1'b0;
            err_count <= '0;
        end else begin
            sym_err <= bad_sym;
            if (start || timeout) begin
                cnt     <= '0;
                bit_cnt <= '0;
            end else if (classify) begin
                // The qualifying edge itself is cycle 1 of the next interval.
                cnt <= CNT_W'(1);
                if (!sym_valid) begin
                    bit_cnt <= '0;
                end else begin
                    shreg   <= word_next;
                    bit_cnt <= complete ? '0 : bit_cnt + BC_W'(1);
                end
            end else if (state == MEASURE && cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (complete && out_valid && !out_ready) begin
                overflow <= 1'b1;
            end else if (complete) begin
                out_data  <= word_next;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (bad_sym && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: doc/pulse_interval_demod.md
PULSE_INTERVAL_DEMOD -- requirements
Module: pulse_interval_demod

Interface
REQ-001 SHALL have parameter CNT_W, default 16: interval counter width in bits.
REQ-002 SHALL have parameter DATA_W, default 8: bits per output word.
REQ-003 SHALL have parameter PERIOD0, default 24900: nominal interval in cycles for symbol 0.
REQ-004 SHALL have parameter PERIOD1, default 21300: nominal interval in cycles for symbol 1.
REQ-005 SHALL have parameter TOL, default 1000: accepted +/- deviation from nominal, in cycles.
REQ-006 SHALL have parameter MIN_LOW, default 16: consecutive low cycles that qualify a gap.
REQ-007 SHALL have parameter TIMEOUT, default 49800: counter value that aborts a frame.
REQ-008 SHALL have port clock, input, 1: single clock; all logic rising-edge.
REQ-009 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-010 SHALL have port insig, input, 1: pulse-gap modulated input.
REQ-011 SHALL have port out_data, output, DATA_W: decoded word.
REQ-012 SHALL have port out_valid, output, 1: out_data holds an unconsumed word.
REQ-013 SHALL have port out_ready, input, 1: consumer accepts the word.
REQ-014 SHALL have port sym_err, output, 1: one-cycle pulse on an invalid interval or a timeout.
REQ-015 SHALL have port overflow, output, 1: sticky flag set when a completed word is dropped.
REQ-016 SHALL have port err_count, output, 8: saturating count of sym_err pulses.

Function
REQ-017 SHALL qualify a gap edge on the cycle the filtered insig has been low for exactly MIN_LOW consecutive cycles; shorter lows are ignored; there is one qualified edge per gap.
REQ-018 SHALL implement FSM states IDLE, ARMED and MEASURE.
REQ-019 SHALL leave IDLE for MEASURE on the first qualified edge, clearing the counter and the bit count; no symbol is produced for this edge.
REQ-020 SHALL, in MEASURE, increment the counter every cycle, saturating at 2^CNT_W-1; on each qualified edge it SHALL classify the counter value and then restart the counter from 1.
REQ-021 SHALL classify the counter value as follows: |count-PERIOD0|<=TOL gives symbol 0; |count-PERIOD1|<=TOL gives symbol 1; any other value is invalid. If both windows match, symbol 1 wins.
REQ-022 SHALL shift each valid symbol into the word LSB-first; the DATA_W-th symbol completes the word.
REQ-023 SHALL, on an invalid interval, pulse sym_err, discard the partial word, set the bit count to 0 and stay in MEASURE (that edge re-arms timing).
REQ-024 SHALL, when the counter reaches TIMEOUT, pulse sym_err, discard the partial word and go to IDLE.
REQ-025 SHALL provide a one-entry output buffer; a completed word loads the buffer, and out_valid rises the cycle after the completing edge.
REQ-026 SHALL complete the transfer when out_valid and out_ready are both high on a clock edge; out_valid and out_data SHALL stay stable until then.
REQ-027 SHALL drop a word that completes while the buffer is full and not being consumed in that same cycle, and set overflow; if the buffer is consumed in the same cycle, the new word loads with no gap.
REQ-028 SHALL hold overflow until reset.
REQ-029 SHALL saturate err_count at 255.
REQ-030 SHALL use ARMED only as the one-cycle state after reset; ARMED always goes to IDLE.

Reset
REQ-031 SHALL, when reset is high on a clock edge, set state=ARMED, counter=0, bit count=0, out_data=0, out_valid=0, sym_err=0, overflow=0, err_count=0.
REQ-032 SHALL discard any partial word and any buffered word when reset is asserted mid-frame.
REQ-033 SHALL clear the glitch-filter run length and the synchronizer flops on reset.

Configuration
REQ-034 SHALL, with macro PID_INSIG_SYNC_EN defined, pass insig through a 2-flop synchronizer reset to 1, adding exactly 2 cycles of latency to every edge.
REQ-035 SHALL, without PID_INSIG_SYNC_EN, use insig directly, and interval values SHALL be identical in both builds.

Verification
REQ-036 SHALL cover: defaults, reset released, then 9 gaps of 100 low cycles spaced to give periods 24900,21300,24900,21300,21300,21300,24900,24900 -> out_data=8'h3A, out_valid high 1 cycle after the 9th edge, sym_err never pulses.
REQ-037 SHALL cover: one period of 23100 mid-word -> sym_err pulses once, err_count=1, partial word discarded, the next 8 valid periods produce a correct word.
REQ-038 SHALL cover: insig low for 10 cycles inside a high phase -> no qualified edge, decode unaffected.
REQ-039 SHALL cover: out_ready held 0 across two full words -> first word held stable, overflow=1, second word lost; out_ready=1 then gives one transfer.
REQ-040 SHALL cover: insig held high for 50000 cycles in MEASURE -> sym_err at count 49800, state IDLE, out_valid stays 0.
REQ-041 SHALL cover: reset pulsed after the 5th symbol -> all outputs 0 on the next cycle, and a fresh 9-gap frame decodes correctly.
